// File: rtl/switch_pkg.sv
// -----------------------------------------------------------------------------
// switch_pkg
//
// Shared types and constants for the switch egress path.
//
//   addr_t        48-bit destination address as driven by the switch core
//   data_t        32-bit destination data
//   sw_entry_t    one queued beat: {addr, data}, addr in the upper bits
//   SW_MCAST_BIT  address bit that marks a multicast destination
//   is_mcast()    true when an address carries the multicast bit
// -----------------------------------------------------------------------------
package switch_pkg;

  typedef logic [47:0] addr_t;
  typedef logic [31:0] data_t;

  typedef struct packed {
    addr_t addr;
    data_t data;
  } sw_entry_t;

  localparam int SW_MCAST_BIT = 40;

  function automatic logic is_mcast(input addr_t addr);
    return addr[SW_MCAST_BIT];
  endfunction

endpackage : switch_pkg

// File: rtl/switch_sat_counter.sv
// -----------------------------------------------------------------------------
// switch_sat_counter
//
// Event counter that sticks at its all-ones value instead of wrapping, so a
// long overload still reads as "at least this many" rather than a small
// number after rollover.
//
// Parameters:
//   W      counter width
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous, active-high reset; clears the count to zero
//   inc    count one event this cycle
//   value  current count, saturating at 2**W-1
// -----------------------------------------------------------------------------
module switch_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] value
);

  logic at_max;

  assign at_max = (value == {W{1'b1}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (inc && !at_max) begin
      value <= value + 1'b1;
    end
  end

endmodule : switch_sat_counter

// File: rtl/switch_egress_fifo.sv
// -----------------------------------------------------------------------------
// switch_egress_fifo
//
// Egress buffer directly behind the switch core. Every beat the switch drives
// is captured into a first-word-fall-through FIFO and offered to the output
// link over a valid/ready handshake. The switch cannot be stalled, so a beat
// that finds no free slot is discarded and counted in drop_cnt.
//
// Parameters:
//   DEPTH   FIFO entries; must be a power of two and at least 2
//   CNT_W   width of the drop / filter counters
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   switch presents a beat this cycle
//   dst_addr   destination address of the beat
//   dst_data   destination data of the beat
//   out_valid  head entry available (registered, = !empty)
//   out_ready  link accepts the head entry
//   out_addr   head entry address, zero while out_valid is low
//   out_data   head entry data, zero while out_valid is low
//   count      current occupancy, 0..DEPTH
//   full       count == DEPTH
//   empty      count == 0
//   drop_cnt   beats lost to overflow, saturating
//   filt_cnt   multicast beats filtered out, saturating
//              (only with SWITCH_EGRESS_FILTER_EN)
//
// Build option:
//   SWITCH_EGRESS_FILTER_EN  when defined, beats whose address has the
//                            multicast bit set are never queued; they are
//                            counted in filt_cnt and never in drop_cnt.
// -----------------------------------------------------------------------------
module switch_egress_fifo
  import switch_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [47:0]              dst_addr,
  input  logic [31:0]              dst_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [47:0]              out_addr,
  output logic [31:0]              out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic [CNT_W-1:0]         drop_cnt
`ifdef SWITCH_EGRESS_FILTER_EN
  ,
  output logic [CNT_W-1:0]         filt_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] FULL_COUNT = OCC_W'(DEPTH);

  typedef logic [PTR_W-1:0] ptr_t;

  // ---------------------------------------------------------------------------
  // Storage and pointers
  // ---------------------------------------------------------------------------
  sw_entry_t mem [DEPTH];
  ptr_t      wr_ptr;
  ptr_t      rd_ptr;
  sw_entry_t head;

  // ---------------------------------------------------------------------------
  // Handshake qualification
  // ---------------------------------------------------------------------------
  logic pop;        // head leaves the FIFO at this edge
  logic candidate;  // beat that wants a slot
  logic push;       // candidate actually written
  logic drop;       // candidate lost for lack of space

  assign pop = out_valid && out_ready;

`ifdef SWITCH_EGRESS_FILTER_EN
  logic filtered;

  // Filtering is decided before space is considered, so a multicast beat
  // arriving at a full FIFO is a filter event, never an overflow.
  assign filtered  = in_valid && is_mcast(dst_addr);
  assign candidate = in_valid && !filtered;
`else
  assign candidate = in_valid;
`endif

  // A full FIFO still takes a beat when the head leaves in the same cycle;
  // this is the only combinational use of out_ready and keeps full-rate
  // streaming at DEPTH occupancy.
  assign push = candidate && (!full || pop);
  assign drop = candidate && !push;

  // ---------------------------------------------------------------------------
  // Pointer and occupancy state
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register in
  // the block samples pre-edge values, matching flip-flop behaviour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // NOTE: the storage array has no reset; count gates which entries are
  // visible, so stale contents after reset are never presented.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{addr: dst_addr, data: dst_data};
    end
  end

  // ---------------------------------------------------------------------------
  // Status and head presentation
  // ---------------------------------------------------------------------------
  assign empty     = (count == '0);
  assign full      = (count == FULL_COUNT);
  assign out_valid = !empty;

  // NOTE: head gets its default before the conditional so every path assigns
  // it and no latch is inferred.
  always_comb begin
    head = '0;
    if (out_valid) begin
      head = mem[rd_ptr];
    end
  end

  assign out_addr = head.addr;
  assign out_data = head.data;

  // ---------------------------------------------------------------------------
  // Event counters
  // ---------------------------------------------------------------------------
  switch_sat_counter #(
    .W (CNT_W)
  ) u_drop_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (drop),
    .value (drop_cnt)
  );

`ifdef SWITCH_EGRESS_FILTER_EN
  switch_sat_counter #(
    .W (CNT_W)
  ) u_filt_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (filtered),
    .value (filt_cnt)
  );
`endif

endmodule : switch_egress_fifo

// File: tb/tb_switch_egress_fifo.sv
// -----------------------------------------------------------------------------
// tb_switch_egress_fifo
//
// Directed bench for switch_egress_fifo (DEPTH=8, CNT_W=16). The driver pushes
// the expected head for every beat it expects to be queued; a separate monitor
// pops and compares on each handshake. Status outputs are checked directly
// against hand-computed values. Define SWITCH_EGRESS_FILTER_EN to include the
// multicast filter scenario.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_switch_egress_fifo;
  import switch_pkg::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = 16;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic [47:0]       dst_addr;
  logic [31:0]       dst_data;
  logic              out_valid;
  logic              out_ready;
  logic [47:0]       out_addr;
  logic [31:0]       out_data;
  logic [3:0]        count;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  drop_cnt;
`ifdef SWITCH_EGRESS_FILTER_EN
  logic [CNT_W-1:0]  filt_cnt;
`endif

  switch_egress_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .dst_addr  (dst_addr),
    .dst_data  (dst_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .drop_cnt  (drop_cnt)
`ifdef SWITCH_EGRESS_FILTER_EN
    ,
    .filt_cnt  (filt_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int        n_cmp  = 0;
  int        n_fail = 0;
  sw_entry_t exp_q[$];

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 ns after the rising edge; outputs are read later in the
  // cycle, well away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input addr_t a, input data_t d, input logic expect_q);
    in_valid = v;
    dst_addr = a;
    dst_data = d;
    if (v && expect_q) exp_q.push_back('{addr: a, data: d});
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    dst_addr = '0;
    dst_data = '0;
  endtask

  // Scoreboard monitor: a handshake visible at the falling edge completes at
  // the next rising edge, so the head shown now must be the oldest expected.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_unexpected: got %h expected no output (t=%0t)",
                 {out_addr, out_data}, $time);
      end else begin
        check("sb_head", {out_addr, out_data}, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst       = 1'b1;
    out_ready = 1'b0;
    idle_in();

    // ---------------- reset and idle ----------------
    #1;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) tick();
    check("idle_empty", empty, 1);
    check("idle_out_valid", out_valid, 0);
    check("idle_count", count, 0);
    check("idle_out_addr", out_addr, 0);
    check("idle_out_data", out_data, 0);
    check("idle_full", full, 0);
    check("idle_drop_cnt", drop_cnt, 0);

    // ---------------- single beat, held head ----------------
    drive(1'b1, 48'h0000_1122_3344, 32'hDEAD_BEEF, 1'b1);
    tick();
    idle_in();
    check("one_out_valid", out_valid, 1);
    check("one_count", count, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_head", {out_addr, out_data}, {48'h0000_1122_3344, 32'hDEAD_BEEF});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("one_empty_after_pop", empty, 1);
    check("one_out_addr_zero", out_addr, 0);

    // ---------------- overflow: 10 beats into 8 slots ----------------
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 48'h0000_AA00_0000 | 48'(i), 32'h1000_0000 + 32'(i), i < DEPTH);
      tick();
    end
    idle_in();
    check("ovf_count", count, 8);
    check("ovf_full", full, 1);
    check("ovf_drop_cnt", drop_cnt, 2);
    out_ready = 1'b1;
    repeat (DEPTH) tick();
    out_ready = 1'b0;
    check("ovf_drained_empty", empty, 1);

    // ---------------- full FIFO, push and pop together ----------------
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 48'h0000_BB00_0000 | 48'(i), 32'h2000_0000 + 32'(i), 1'b1);
      tick();
    end
    check("sim_full_before", full, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 48'h0000_CC00_0000 | 48'(i), 32'h3000_0000 + 32'(i), 1'b1);
      tick();
      check("sim_count_stays", count, 8);
    end
    idle_in();
    check("sim_drop_unchanged", drop_cnt, 2);
    repeat (DEPTH) tick();
    out_ready = 1'b0;
    check("sim_drained_empty", empty, 1);

    // ---------------- reset mid-burst ----------------
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 48'h0000_DD00_0000 | 48'(i), 32'h4000_0000 + 32'(i), 1'b1);
      tick();
    end
    check("mid_count5", count, 5);
    drive(1'b1, 48'h0000_DD00_0005, 32'h4000_0005, 1'b0);
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    check("mid_rst_count", count, 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_addr", out_addr, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_full", full, 0);
    check("mid_rst_drop_cnt", drop_cnt, 0);
    idle_in();
    tick();
    rst = 1'b0;
    tick();
    drive(1'b1, 48'h0000_EE00_0001, 32'h5555_AAAA, 1'b1);
    tick();
    idle_in();
    check("post_rst_count", count, 1);
    check("post_rst_head", {out_addr, out_data}, {48'h0000_EE00_0001, 32'h5555_AAAA});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("post_rst_empty", empty, 1);

`ifdef SWITCH_EGRESS_FILTER_EN
    // ---------------- multicast filter ----------------
    drive(1'b1, 48'h0100_0000_0000, 32'h0BAD_F00D, 1'b0);
    tick();
    idle_in();
    check("filt_not_queued", count, 0);
    check("filt_cnt_1", filt_cnt, 1);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 48'h0000_FF00_0000 | 48'(i), 32'h6000_0000 + 32'(i), 1'b1);
      tick();
    end
    drive(1'b1, 48'h0100_0000_0000, 32'h0BAD_F00D, 1'b0);
    tick();
    idle_in();
    check("filt_cnt_2", filt_cnt, 2);
    check("filt_drop_unchanged", drop_cnt, 0);
    check("filt_full_count", count, 8);
    out_ready = 1'b1;
    repeat (DEPTH) tick();
    out_ready = 1'b0;
    check("filt_drained_empty", empty, 1);
`endif

    tick();
    check("sb_all_consumed", 80'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_switch_egress_fifo
